// File: rtl/pcs_rx_receive_if.sv
// Bundles the synchronization-side inputs and GMII-side outputs of the PCS receive block.
interface pcs_rx_receive_if;
    logic       SYNC_STATUS;
    logic [9:0] RX_CODE_GROUP;
    logic [7:0] RXD;
    logic       RX_DV;
    logic       RX_ER;
    logic       RECEIVING;

    modport master (
        output SYNC_STATUS,
        output RX_CODE_GROUP,
        input  RXD,
        input  RX_DV,
        input  RX_ER,
        input  RECEIVING
    );

    modport slave (
        input  SYNC_STATUS,
        input  RX_CODE_GROUP,
        output RXD,
        output RX_DV,
        output RX_ER,
        output RECEIVING
    );
endinterface

// File: rtl/pcs_rx_receive.sv
// 1000BASE-X PCS receive path: 8b/10b decode plus a reduced receive state machine
// driving registered GMII-side RXD/RX_DV/RX_ER/RECEIVING.
//
// state           | meaning
// ----------------+----------------------------------------------------------
// LINK_FAILED     | no code-group alignment; all outputs held low
// WAIT_FOR_K      | hunting for a K28.5 comma
// RX_K            | K28.5 seen; expecting the idle data octet (D16.2 / D5.6)
// IDLE_D          | complete idle ordered set seen; /S/ may start a packet
// START_OF_PACKET | /S/ accepted; preamble octet 0x55 presented
// RECEIVE         | in packet; data octets forwarded
// TRI_RRI         | /T/ seen; absorbing /R/ until the next comma
module pcs_rx_receive #(
    parameter bit IDLE_CHECK = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    pcs_rx_receive_if.slave   rx
);

    localparam logic [2:0] LINK_FAILED     = 3'd0;
    localparam logic [2:0] WAIT_FOR_K      = 3'd1;
    localparam logic [2:0] RX_K            = 3'd2;
    localparam logic [2:0] IDLE_D          = 3'd3;
    localparam logic [2:0] START_OF_PACKET = 3'd4;
    localparam logic [2:0] RECEIVE         = 3'd5;
    localparam logic [2:0] TRI_RRI         = 3'd6;

    logic [2:0] state, state_nxt;
    logic [7:0] rxd_nxt;
    logic       rx_dv_nxt, rx_er_nxt, receiving_nxt;

    logic [5:0] g6;
    logic [3:0] g4;
    logic [4:0] edcba;
    logic [2:0] hgf;
    logic       v6, v4, k28_6, alt7;
    logic       is_data, is_k28_5, is_s, is_t, is_r, k_x7;
    logic [7:0] dec;

    assign g6 = rx.RX_CODE_GROUP[9:4];
    assign g4 = rx.RX_CODE_GROUP[3:0];

    // 6b -> 5b lookup, both running-disparity columns; K28 flagged separately
    always_comb begin
        edcba = 5'd0;
        v6    = 1'b1;
        k28_6 = 1'b0;
        case (g6)
            6'b100111, 6'b011000: edcba = 5'd0;
            6'b011101, 6'b100010: edcba = 5'd1;
            6'b101101, 6'b010010: edcba = 5'd2;
            6'b110001:            edcba = 5'd3;
            6'b110101, 6'b001010: edcba = 5'd4;
            6'b101001:            edcba = 5'd5;
            6'b011001:            edcba = 5'd6;
            6'b111000, 6'b000111: edcba = 5'd7;
            6'b111001, 6'b000110: edcba = 5'd8;
            6'b100101:            edcba = 5'd9;
            6'b010101:            edcba = 5'd10;
            6'b110100:            edcba = 5'd11;
            6'b001101:            edcba = 5'd12;
            6'b101100:            edcba = 5'd13;
            6'b011100:            edcba = 5'd14;
            6'b010111, 6'b101000: edcba = 5'd15;
            6'b011011, 6'b100100: edcba = 5'd16;
            6'b100011:            edcba = 5'd17;
            6'b010011:            edcba = 5'd18;
            6'b110010:            edcba = 5'd19;
            6'b001011:            edcba = 5'd20;
            6'b101010:            edcba = 5'd21;
            6'b011010:            edcba = 5'd22;
            6'b111010, 6'b000101: edcba = 5'd23;
            6'b110011, 6'b001100: edcba = 5'd24;
            6'b100110:            edcba = 5'd25;
            6'b010110:            edcba = 5'd26;
            6'b110110, 6'b001001: edcba = 5'd27;
            6'b001110:            edcba = 5'd28;
            6'b101110, 6'b010001: edcba = 5'd29;
            6'b011110, 6'b100001: edcba = 5'd30;
            6'b101011, 6'b010100: edcba = 5'd31;
            6'b001111, 6'b110000: begin
                edcba = 5'd28;
                v6    = 1'b0;
                k28_6 = 1'b1;
            end
            default:              v6 = 1'b0;
        endcase
    end

    // 4b -> 3b lookup; alt7 marks the A7 pattern that doubles as the K.x.7 suffix
    always_comb begin
        hgf  = 3'd0;
        v4   = 1'b1;
        alt7 = 1'b0;
        case (g4)
            4'b1011, 4'b0100: hgf = 3'd0;
            4'b1001:          hgf = 3'd1;
            4'b0101:          hgf = 3'd2;
            4'b1100, 4'b0011: hgf = 3'd3;
            4'b1101, 4'b0010: hgf = 3'd4;
            4'b1010:          hgf = 3'd5;
            4'b0110:          hgf = 3'd6;
            4'b1110, 4'b0001: hgf = 3'd7;
            4'b0111, 4'b1000: begin
                hgf  = 3'd7;
                alt7 = 1'b1;
            end
            default:          v4 = 1'b0;
        endcase
    end

    // A7 after the 6b codes of 23/27/29/30 is a control group, never data;
    // K30.7 and every K28.y other than K28.5 fall through as invalid.
    assign k_x7     = v6 && alt7 && (edcba == 5'd23 || edcba == 5'd27 ||
                                     edcba == 5'd29 || edcba == 5'd30);
    assign is_k28_5 = k28_6 && (g4 == 4'b1010 || g4 == 4'b0101);
    assign is_s     = k_x7 && (edcba == 5'd27);
    assign is_t     = k_x7 && (edcba == 5'd29);
    assign is_r     = k_x7 && (edcba == 5'd23);
    assign is_data  = v6 && v4 && !k_x7;
    assign dec      = {hgf, edcba};

    // Next state and next registered outputs; sync loss overrides everything
    always_comb begin
        state_nxt     = state;
        rxd_nxt       = 8'h00;
        rx_dv_nxt     = 1'b0;
        rx_er_nxt     = 1'b0;
        receiving_nxt = 1'b0;
        if (!rx.SYNC_STATUS) begin
            state_nxt = LINK_FAILED;
        end else begin
            case (state)
                LINK_FAILED: state_nxt = WAIT_FOR_K;
                WAIT_FOR_K: begin
                    if (is_k28_5) state_nxt = RX_K;
                end
                RX_K: begin
                    if (is_data && (dec == 8'h50 || dec == 8'hC5)) begin
                        state_nxt = IDLE_D;
                    end else if (!IDLE_CHECK && is_s) begin
                        state_nxt     = START_OF_PACKET;
                        rxd_nxt       = 8'h55;
                        rx_dv_nxt     = 1'b1;
                        receiving_nxt = 1'b1;
                    end else begin
                        state_nxt = WAIT_FOR_K;
                    end
                end
                IDLE_D: begin
                    if (is_k28_5) begin
                        state_nxt = RX_K;
                    end else if (is_s) begin
                        state_nxt     = START_OF_PACKET;
                        rxd_nxt       = 8'h55;
                        rx_dv_nxt     = 1'b1;
                        receiving_nxt = 1'b1;
                    end else begin
                        state_nxt = WAIT_FOR_K;
                    end
                end
                START_OF_PACKET, RECEIVE: begin
                    if (is_data) begin
                        state_nxt     = RECEIVE;
                        rxd_nxt       = dec;
                        rx_dv_nxt     = 1'b1;
                        receiving_nxt = 1'b1;
                    end else if (is_t) begin
                        state_nxt = TRI_RRI;
                    end else if (is_k28_5) begin
                        state_nxt = RX_K;
                        rx_er_nxt = 1'b1;
                    end else begin
                        // invalid or out-of-place control group: flag and keep receiving
                        state_nxt     = RECEIVE;
                        rx_dv_nxt     = 1'b1;
                        rx_er_nxt     = 1'b1;
                        receiving_nxt = 1'b1;
                    end
                end
                TRI_RRI: begin
                    if (is_k28_5)  state_nxt = RX_K;
                    else if (!is_r) state_nxt = WAIT_FOR_K;
                end
                default: state_nxt = LINK_FAILED;
            endcase
        end
    end

    // State and output registers with asynchronous active-low clear
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= LINK_FAILED;
            rx.RXD       <= 8'h00;
            rx.RX_DV     <= 1'b0;
            rx.RX_ER     <= 1'b0;
            rx.RECEIVING <= 1'b0;
        end else begin
            state        <= state_nxt;
            rx.RXD       <= rxd_nxt;
            rx.RX_DV     <= rx_dv_nxt;
            rx.RX_ER     <= rx_er_nxt;
            rx.RECEIVING <= receiving_nxt;
        end
    end

endmodule

// File: tb/tb_pcs_rx_receive.sv
// Directed self-checking bench for pcs_rx_receive (IDLE_CHECK = 1).
// Each vector is {SYNC_STATUS, RX_CODE_GROUP}; each expectation is
// {RXD, RX_DV, RX_ER, RECEIVING} observed just after the sampling edge.
module tb_pcs_rx_receive;

    logic CLK;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    pcs_rx_receive_if vif ();

    pcs_rx_receive #(.IDLE_CHECK(1'b1)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .rx    (vif.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic [10:0] E0   = 11'h000;
    localparam logic [10:0] E55  = {8'h55, 3'b101};
    localparam logic [10:0] EAA  = {8'hAA, 3'b101};
    localparam logic [10:0] EINV = {8'h00, 3'b111};
    localparam logic [10:0] EEND = {8'h00, 3'b010};

    function automatic logic [10:0] on(input logic [9:0] cg);
        return {1'b1, cg};
    endfunction

    function automatic logic [10:0] off(input logic [9:0] cg);
        return {1'b0, cg};
    endfunction

    function automatic logic [10:0] dat(input logic [7:0] b);
        return {b, 3'b101};
    endfunction

    // Leaves the DUT in LINK_FAILED with RESET released, aligned to posedge+1
    task automatic apply_reset();
        RESET = 1'b0;
        vif.SYNC_STATUS = 1'b0;
        vif.RX_CODE_GROUP = 10'h000;
        @(posedge CLK); #1;
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] stim [$];
        logic [10:0] exp [$];
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vif.SYNC_STATUS = i[0];
            vif.RX_CODE_GROUP = (i[1]) ? 10'h368 : 10'h0FA;
            @(posedge CLK); #1;
            checks++;
            if ({vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING} !== E0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h want %h", i,
                         {vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING}, E0);
            end
        end
        RESET = 1'b1;
        // sync low keeps LINK_FAILED; on sync rise the first group is spent
        // leaving LINK_FAILED, so 0FA 245 368 must not start a packet
        stim = '{off(10'h0FA), off(10'h245), off(10'h368),
                 on(10'h0FA), on(10'h245), on(10'h368),
                 on(10'h0FA), on(10'h245), on(10'h368)};
        exp  = '{E0, E0, E0, E0, E0, E0, E0, E0, E55};
        for (int i = 0; i < stim.size(); i++) begin
            vif.SYNC_STATUS = stim[i][10];
            vif.RX_CODE_GROUP = stim[i][9:0];
            @(posedge CLK); #1;
            checks++;
            if ({vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING} !== exp[i]) begin
                errors++;
                $display("FAIL reset_release step %0d: got %h want %h", i,
                         {vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING}, exp[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] stim [$];
        logic [10:0] exp [$];
        apply_reset();
        stim = '{on(10'h0FA), on(10'h245), on(10'h0FA), on(10'h245),
                 on(10'h368), on(10'h15A)};
        exp  = '{E0, E0, E0, E0, E55, EAA};
        for (int i = 0; i < stim.size(); i++) begin
            vif.SYNC_STATUS = stim[i][10];
            vif.RX_CODE_GROUP = stim[i][9:0];
            @(posedge CLK); #1;
            checks++;
            if ({vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING} !== exp[i]) begin
                errors++;
                $display("FAIL async_pre step %0d: got %h want %h", i,
                         {vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING}, exp[i]);
            end
        end
        #3 RESET = 1'b0;
        #1;
        checks++;
        if ({vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING} !== E0) begin
            errors++;
            $display("FAIL async_clear: got %h want %h",
                     {vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING}, E0);
        end
        @(posedge CLK); #1;
        RESET = 1'b1;
    endtask

    task automatic test_idle_packet();
        logic [10:0] stim [$];
        logic [10:0] exp [$];
        apply_reset();
        stim = '{on(10'h0FA), on(10'h245), on(10'h0FA), on(10'h245), on(10'h368),
                 on(10'h15A), on(10'h15A), on(10'h2E8), on(10'h057), on(10'h0FA),
                 on(10'h245), on(10'h368), on(10'h2E8), on(10'h057), on(10'h057),
                 on(10'h15A), on(10'h368)};
        exp  = '{E0, E0, E0, E0, E55,
                 EAA, EAA, E0, E0, E0,
                 E0, E55, E0, E0, E0,
                 E0, E0};
        for (int i = 0; i < stim.size(); i++) begin
            vif.SYNC_STATUS = stim[i][10];
            vif.RX_CODE_GROUP = stim[i][9:0];
            @(posedge CLK); #1;
            checks++;
            if ({vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING} !== exp[i]) begin
                errors++;
                $display("FAIL idle_packet step %0d: got %h want %h", i,
                         {vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING}, exp[i]);
            end
        end
    endtask

    task automatic test_invalid_and_decode();
        logic [10:0] stim [$];
        logic [10:0] exp [$];
        apply_reset();
        stim = '{on(10'h0FA), on(10'h245), on(10'h0FA), on(10'h296), on(10'h368),
                 on(10'h000), on(10'h15A), on(10'h2AA), on(10'h274), on(10'h2BE),
                 on(10'h3AE), on(10'h237), on(10'h1EE), on(10'h0F4), on(10'h1E8),
                 on(10'h296), on(10'h2E8)};
        exp  = '{E0, E0, E0, E0, E55,
                 EINV, EAA, dat(8'hB5), dat(8'h00), dat(8'hFF),
                 dat(8'hF7), dat(8'hF1), dat(8'hFE), EINV, EINV,
                 dat(8'hC5), E0};
        for (int i = 0; i < stim.size(); i++) begin
            vif.SYNC_STATUS = stim[i][10];
            vif.RX_CODE_GROUP = stim[i][9:0];
            @(posedge CLK); #1;
            checks++;
            if ({vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING} !== exp[i]) begin
                errors++;
                $display("FAIL invalid_decode step %0d: got %h want %h", i,
                         {vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING}, exp[i]);
            end
        end
    endtask

    task automatic test_early_end();
        logic [10:0] stim [$];
        logic [10:0] exp [$];
        apply_reset();
        stim = '{on(10'h0FA), on(10'h245), on(10'h0FA), on(10'h245), on(10'h368),
                 on(10'h15A), on(10'h0FA), on(10'h245), on(10'h368), on(10'h15A),
                 on(10'h2E8)};
        exp  = '{E0, E0, E0, E0, E55,
                 EAA, EEND, E0, E55, EAA,
                 E0};
        for (int i = 0; i < stim.size(); i++) begin
            vif.SYNC_STATUS = stim[i][10];
            vif.RX_CODE_GROUP = stim[i][9:0];
            @(posedge CLK); #1;
            checks++;
            if ({vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING} !== exp[i]) begin
                errors++;
                $display("FAIL early_end step %0d: got %h want %h", i,
                         {vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING}, exp[i]);
            end
        end
    endtask

    task automatic test_sync_loss();
        logic [10:0] stim [$];
        logic [10:0] exp [$];
        apply_reset();
        // second drop coincides with a K28.5 mid-packet: sync loss wins, no RX_ER
        stim = '{on(10'h0FA), on(10'h245), on(10'h0FA), on(10'h245), on(10'h368),
                 on(10'h15A), off(10'h15A), on(10'h15A), on(10'h15A), on(10'h368),
                 on(10'h245), on(10'h368), on(10'h0FA), on(10'h245), on(10'h368),
                 off(10'h0FA), on(10'h0FA)};
        exp  = '{E0, E0, E0, E0, E55,
                 EAA, E0, E0, E0, E0,
                 E0, E0, E0, E0, E55,
                 E0, E0};
        for (int i = 0; i < stim.size(); i++) begin
            vif.SYNC_STATUS = stim[i][10];
            vif.RX_CODE_GROUP = stim[i][9:0];
            @(posedge CLK); #1;
            checks++;
            if ({vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING} !== exp[i]) begin
                errors++;
                $display("FAIL sync_loss step %0d: got %h want %h", i,
                         {vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING}, exp[i]);
            end
        end
    endtask

    task automatic test_idle_check();
        logic [10:0] stim [$];
        logic [10:0] exp [$];
        apply_reset();
        // /S/ right after K28.5 is refused; a full idle then /S/ is accepted
        stim = '{on(10'h15A), on(10'h0FA), on(10'h368), on(10'h15A), on(10'h368),
                 on(10'h0FA), on(10'h296), on(10'h368), on(10'h15A), on(10'h2E8)};
        exp  = '{E0, E0, E0, E0, E0,
                 E0, E0, E55, EAA, E0};
        for (int i = 0; i < stim.size(); i++) begin
            vif.SYNC_STATUS = stim[i][10];
            vif.RX_CODE_GROUP = stim[i][9:0];
            @(posedge CLK); #1;
            checks++;
            if ({vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING} !== exp[i]) begin
                errors++;
                $display("FAIL idle_check step %0d: got %h want %h", i,
                         {vif.RXD, vif.RX_DV, vif.RX_ER, vif.RECEIVING}, exp[i]);
            end
        end
    endtask

    initial begin
        RESET = 1'b0;
        vif.SYNC_STATUS = 1'b0;
        vif.RX_CODE_GROUP = 10'h000;
        #1;
        test_reset();
        test_async_reset();
        test_idle_packet();
        test_invalid_and_decode();
        test_early_end();
        test_sync_loss();
        test_idle_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcs_rx_receive.md
Name: pcs_rx_receive

Overview:
- Receive half of the 1000BASE-X PCS; mirror of the transmit path that takes TX_EN_/TXD_ and produces 10-bit code-groups.
- Consumes 10-bit code-groups plus SYNC_STATUS from the synchronization block.
- Performs 8b/10b decode and runs a reduced Clause-36 receive state machine.
- Drives the GMII-side RXD/RX_DV/RX_ER toward the tester.

Parameters:
- IDLE_CHECK, 1, 1 requires K28.5 followed by D16.2 or D5.6 before packet start is accepted; 0 accepts /S/ directly after any K28.5.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- SYNC_STATUS  input  1  1 = code-group alignment acquired.
- RX_CODE_GROUP  input  10  bits [9:4] = abcdei, [3:0] = fghj; bit 9 (a) is first on the line.
- RXD  output  8  decoded octet: [4:0] = EDCBA from 5b/6b, [7:5] = HGF from 3b/4b.
- RX_DV  output  1  data valid.
- RX_ER  output  1  receive error.
- RECEIVING  output  1  high from /S/ until the end of packet.

Behaviour:
- Reset (RESET = 0, asynchronous): state = LINK_FAILED; RXD = 8'h00; RX_DV = 0; RX_ER = 0; RECEIVING = 0.
- All outputs are registered. A code-group sampled at edge N is reflected on the outputs after edge N, i.e. one-cycle latency.
- Decode:
  - Combinational 6b→5b and 4b→3b lookup accepting both running-disparity columns.
  - Running disparity is not checked.
  - Recognized K groups: K28.5, K27.7 (/S/), K29.7 (/T/), K23.7 (/R/).
  - Any unlisted 6b or 4b pattern, or any other K group, is INVALID.
- States:
  - LINK_FAILED: outputs 0. SYNC_STATUS = 1 → WAIT_FOR_K.
  - WAIT_FOR_K: outputs 0. K28.5 → RX_K; else stay.
  - RX_K: D16.2 or D5.6 → IDLE_D; anything else → WAIT_FOR_K.
    - With IDLE_CHECK = 0, /S/ is also accepted here → START_OF_PACKET.
  - IDLE_D: K28.5 → RX_K; /S/ → START_OF_PACKET; else → WAIT_FOR_K.
  - START_OF_PACKET: RXD = 8'h55, RX_DV = 1, RECEIVING = 1. Transitions are evaluated on the next code-group using the RECEIVE rules.
  - RECEIVE: action depends on the code-group.
    - Data code-group: RXD = decoded value, RX_DV = 1.
    - /T/ → TRI_RRI, with RX_DV = 0 and RXD = 8'h00.
    - K28.5 (early end): RX_ER = 1, RX_DV = 0, RECEIVING = 0 for one cycle → RX_K.
    - INVALID: RX_ER = 1, RX_DV = 1, RXD = 8'h00; stay in RECEIVE.
  - TRI_RRI: RECEIVING = 0. /R/ → stay; K28.5 → RX_K; any other code-group → WAIT_FOR_K.
- RX_ER is a one-cycle pulse; it clears on the next code-group unless the error repeats.
- SYNC_STATUS = 0 in any state forces LINK_FAILED on the next edge and clears all outputs, including mid-packet. No RX_ER is raised in this case.
- Simultaneous events: SYNC_STATUS loss has priority over every code-group decision.
- Asynchronous reset asserted mid-packet clears outputs immediately, without waiting for CLK.

Test Plan:
- Reset and sync-loss clearing:
  - Hold RESET = 0, toggle inputs → RXD = 00, RX_DV = 0, RX_ER = 0, RECEIVING = 0 throughout.
  - Release RESET with SYNC_STATUS = 0 → state remains LINK_FAILED.
- Idle then packet:
  - Stimulus: SYNC_STATUS = 1; code-groups 0x0FA, 0x245, 0x0FA, 0x245, 0x368 (/S/), 0x15A, 0x15A, 0x2E8 (/T/), 0x057 (/R/), 0x0FA.
  - Response: RX_DV rises one cycle after /S/ with RXD = 55, followed by two cycles of RXD = AA.
  - RX_DV falls one cycle after /T/; RECEIVING spans /S/ through the last data cycle.
- Invalid code-group mid-packet:
  - Replace the first 0x15A with 0x000.
  - Response: exactly one cycle of RX_ER = 1, RX_DV = 1, RXD = 00; the next 0x15A yields RXD = AA with RX_ER = 0.
- Early end:
  - Follow /S/ and one 0x15A with 0x0FA.
  - Response: one-cycle RX_ER = 1 with RX_DV = 0; a subsequent 0x245 then 0x368 starts a new packet normally.
- Sync loss mid-packet:
  - Drop SYNC_STATUS during data.
  - Response: next edge gives RX_DV = 0, RECEIVING = 0, RX_ER = 0.
  - Restoring SYNC_STATUS without K28.5 keeps the outputs low.
- IDLE_CHECK = 1 rejection:
  - Code-groups 0x0FA then 0x368 directly.
  - Response: no RX_DV; the block returns to WAIT_FOR_K.
